// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: generic valid/ready pipeline register with an optional
// two-entry skid buffer. The main register always drives the outputs. The
// skid register catches the one extra beat that arrives while in_ready_o is
// still registered high. Bubble cycles zero the KILL_MASK bits of payload_o.
module pipe_stage_skid #(
  parameter int                   PAYLOAD_W = 144,
  parameter logic [PAYLOAD_W-1:0] RESET_VAL = {PAYLOAD_W{1'b0}},
  parameter logic [PAYLOAD_W-1:0] KILL_MASK = {PAYLOAD_W{1'b1}},
  parameter bit                   SKID_EN   = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [PAYLOAD_W-1:0] payload_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [PAYLOAD_W-1:0] payload_o,
  output logic [1:0]           occupancy_o
);

  logic [PAYLOAD_W-1:0] w_main;
  logic                 w_mainValid;
  logic                 w_accept;
  logic                 w_pop;

  assign w_accept    = in_valid_i & in_ready_o;
  assign w_pop       = w_mainValid & out_ready_i;
  assign out_valid_o = w_mainValid;
  // A bubble still shows stale main data, but control bits are cleared.
  assign payload_o   = w_mainValid ? w_main : (w_main & ~KILL_MASK);

  if (SKID_EN) begin : g_skid
    // occupancy is the state encoding itself: 0, 1 or 2 held entries
    typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
    } state_t;

    state_t               r_state;
    logic [PAYLOAD_W-1:0] r_main;
    logic [PAYLOAD_W-1:0] r_skid;
    logic                 r_inReady;

    // Skid FSM: in_ready drops only once the skid slot is in use.
    always_ff @(posedge clk_i) begin
      if (!rst_i || flush_i) begin
        r_state   <= EMPTY;
        r_main    <= RESET_VAL;
        r_skid    <= RESET_VAL;
        r_inReady <= 1'b1;
      end else begin
        case (r_state)
          EMPTY: begin
            if (w_accept) begin
              r_main  <= payload_i;
              r_state <= ONE;
            end
          end
          ONE: begin
            if (w_accept && w_pop) begin
              r_main <= payload_i;
            end else if (w_accept) begin
              r_skid    <= payload_i;
              r_state   <= FULL;
              r_inReady <= 1'b0;
            end else if (w_pop) begin
              r_state <= EMPTY;
            end
          end
          FULL: begin
            if (w_pop) begin
              r_main    <= r_skid;
              r_state   <= ONE;
              r_inReady <= 1'b1;
            end
          end
          default: begin
            r_state   <= EMPTY;
            r_inReady <= 1'b1;
          end
        endcase
      end
    end

    assign w_main      = r_main;
    assign w_mainValid = (r_state != EMPTY);
    assign in_ready_o  = r_inReady;
    assign occupancy_o = r_state;
  end else begin : g_noSkid
    logic [PAYLOAD_W-1:0] r_main;
    logic                 r_mainValid;

    // Single register: refill on accept, otherwise drain on pop.
    always_ff @(posedge clk_i) begin
      if (!rst_i || flush_i) begin
        r_main      <= RESET_VAL;
        r_mainValid <= 1'b0;
      end else if (w_accept) begin
        r_main      <= payload_i;
        r_mainValid <= 1'b1;
      end else if (w_pop) begin
        r_mainValid <= 1'b0;
      end
    end

    assign w_main      = r_main;
    assign w_mainValid = r_mainValid;
    assign in_ready_o  = ~r_mainValid | out_ready_i;
    assign occupancy_o = {1'b0, r_mainValid};
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: drives a skid instance (A) and a single-register
// instance (B) from a shared clock. A queue per instance holds the payloads
// the stage should currently contain; outputs are compared against it.
module tb_pipe_stage_skid;

  localparam int         W       = 32;
  localparam logic [W-1:0] A_RESET = 32'h0000_0000;
  localparam logic [W-1:0] A_KILL  = 32'h0000_000F;
  localparam logic [W-1:0] B_RESET = 32'h0000_00F7;
  localparam logic [W-1:0] B_KILL  = 32'h0000_000C;

  logic clk = 1'b0;
  logic rst;

  logic         aFlush, aInValid, aInReady, aOutValid, aOutReady;
  logic [W-1:0] aPayIn, aPayOut;
  logic [1:0]   aOcc;
  logic         bFlush, bInValid, bInReady, bOutValid, bOutReady;
  logic [W-1:0] bPayIn, bPayOut;
  logic [1:0]   bOcc;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] qA[$];
  logic [W-1:0] qB[$];
  logic [W-1:0] lastA;
  logic [W-1:0] lastB;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .PAYLOAD_W(W), .RESET_VAL(A_RESET), .KILL_MASK(A_KILL), .SKID_EN(1'b1)
  ) dutA (
    .clk_i(clk), .rst_i(rst), .flush_i(aFlush),
    .in_valid_i(aInValid), .in_ready_o(aInReady), .payload_i(aPayIn),
    .out_valid_o(aOutValid), .out_ready_i(aOutReady), .payload_o(aPayOut),
    .occupancy_o(aOcc)
  );

  pipe_stage_skid #(
    .PAYLOAD_W(W), .RESET_VAL(B_RESET), .KILL_MASK(B_KILL), .SKID_EN(1'b0)
  ) dutB (
    .clk_i(clk), .rst_i(rst), .flush_i(bFlush),
    .in_valid_i(bInValid), .in_ready_o(bInReady), .payload_i(bPayIn),
    .out_valid_o(bOutValid), .out_ready_i(bOutReady), .payload_o(bPayOut),
    .occupancy_o(bOcc)
  );

  task automatic checkOutput(input string tag, input logic [W-1:0] obs,
                             input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus on instance A (useSkid=1) or B (useSkid=0):
  // drive, check at the falling edge, then advance the reference queue.
  task automatic applyStimulus(input bit useSkid, input logic vld,
                               input logic [W-1:0] data, input logic rdy,
                               input logic flush, output bit accepted);
    logic expReady;
    bit   pop;
    int   size;
    if (useSkid) begin
      aInValid = vld; aPayIn = data; aOutReady = rdy; aFlush = flush;
    end else begin
      bInValid = vld; bPayIn = data; bOutReady = rdy; bFlush = flush;
    end
    @(negedge clk);
    if (useSkid) begin
      size     = qA.size();
      expReady = (size < 2);
      checkOutput("A_inReady", {31'b0, aInReady}, {31'b0, expReady});
      checkOutput("A_occ", {30'b0, aOcc}, W'(size));
      checkOutput("A_outValid", {31'b0, aOutValid}, {31'b0, (size > 0)});
      checkOutput("A_payload", aPayOut, (size > 0) ? qA[0] : (lastA & ~A_KILL));
    end else begin
      size     = qB.size();
      expReady = (size == 0) || rdy;
      checkOutput("B_inReady", {31'b0, bInReady}, {31'b0, expReady});
      checkOutput("B_occ", {30'b0, bOcc}, W'(size));
      checkOutput("B_outValid", {31'b0, bOutValid}, {31'b0, (size > 0)});
      checkOutput("B_payload", bPayOut, (size > 0) ? qB[0] : (lastB & ~B_KILL));
    end
    pop      = (size > 0) && rdy;
    accepted = vld && expReady;
    @(posedge clk);
    #1;
    if (useSkid) begin
      if (flush) begin
        qA.delete();
        lastA = A_RESET;
      end else begin
        if (pop) void'(qA.pop_front());
        if (accepted) qA.push_back(data);
        if (qA.size() > 0) lastA = qA[0];
      end
      aInValid = 1'b0; aFlush = 1'b0;
    end else begin
      if (flush) begin
        qB.delete();
        lastB = B_RESET;
      end else begin
        if (pop) void'(qB.pop_front());
        if (accepted) qB.push_back(data);
        if (qB.size() > 0) lastB = qB[0];
      end
      bInValid = 1'b0; bFlush = 1'b0;
    end
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Main sequence: reset, then skid scenarios, then single-register scenarios.
  initial begin
    bit           acc;
    logic [W-1:0] nextVal;

    rst = 1'b0;
    aFlush = 1'b0; aInValid = 1'b1; aPayIn = 32'hABCD; aOutReady = 1'b0;
    bFlush = 1'b0; bInValid = 1'b1; bPayIn = 32'hABCD; bOutReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    aInValid = 1'b0; bInValid = 1'b0;
    lastA = A_RESET;
    lastB = B_RESET;

    // Reset state of A.
    applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, acc);

    // Streaming 1..8 at full rate, then drain.
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 1'b1, W'(i), 1'b1, 1'b0, acc);
    applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, acc);

    // Backpressure: 5 in main, 6 in skid, 7 held upstream.
    applyStimulus(1'b1, 1'b1, 32'd5, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 1'b1, 32'd6, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 1'b1, 32'd7, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 1'b1, 32'd7, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 1'b1, 32'd7, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, 1'b1, 32'd7, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, acc);

    // Bubble masking: stale 0x12345 shows as 0x12340 once popped.
    applyStimulus(1'b1, 1'b1, 32'h12345, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, acc);
    checkOutput("A_bubbleValid", {31'b0, aOutValid}, 32'd0);
    checkOutput("A_bubbleMask", aPayOut, 32'h0001_2340);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, acc);

    // Flush while FULL with an accept attempt, then a lone 0x55.
    applyStimulus(1'b1, 1'b1, 32'h21, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 1'b1, 32'h22, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 1'b1, 32'h99, 1'b0, 1'b1, acc);
    applyStimulus(1'b1, 1'b1, 32'h55, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, acc);

    // Reset mid-transfer discards held entries and beats flush.
    applyStimulus(1'b1, 1'b1, 32'h77, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 1'b1, 32'h78, 1'b0, 1'b0, acc);
    rst = 1'b0; aFlush = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1; aFlush = 1'b0;
    qA.delete(); lastA = A_RESET;
    qB.delete(); lastB = B_RESET;
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, acc);

    // Single register: reset value, then continuous input with ready toggling.
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, acc);
    nextVal = 32'h100;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, nextVal, (i % 2 == 0), 1'b0, acc);
      if (acc) nextVal = nextVal + 1;
    end
    applyStimulus(1'b0, 1'b1, nextVal, 1'b0, 1'b1, acc);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, acc);
    applyStimulus(1'b0, 1'b1, 32'h55, 1'b0, 1'b0, acc);
    applyStimulus(1'b0, 1'b1, 32'h56, 1'b1, 1'b0, acc);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, acc);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, acc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Generic, parametrised pipeline stage register that replaces the hand-written per-stage latches such as execute→memory, memory→writeback and the CSR side-band. It carries an opaque payload bus with a valid/ready handshake on both sides. A 2-entry skid buffer lets it sustain full throughput with a registered in_ready_o. It supports synchronous flush and forces selected payload bits (write enables, op codes) to zero whenever the stage holds a bubble.

Parameters:
PAYLOAD_W, 144, width of payload_i/payload_o in bits (sized to pack reg/mem/CSR fields).
RESET_VAL, {PAYLOAD_W{1'b0}}, value loaded into both storage registers on reset and flush.
KILL_MASK, {PAYLOAD_W{1'b1}}, bits of payload_o forced to 0 while out_valid_o=0.
SKID_EN, 1, 1 = two-entry skid with registered in_ready_o; 0 = single register with combinational in_ready_o.

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  reset, synchronous, active-low
flush_i  input  1  synchronous kill of all held entries
in_valid_i  input  1  upstream has a payload
in_ready_o  output  1  stage can accept this cycle
payload_i  input  PAYLOAD_W  upstream payload
out_valid_o  output  1  main register holds a valid entry
out_ready_i  input  1  downstream accepts this cycle
payload_o  output  PAYLOAD_W  main register payload, masked by KILL_MASK when invalid
occupancy_o  output  2  number of valid entries (0..2)

Behaviour:
- Storage: main register M with valid bit mv, which drives the outputs. Skid register S with valid bit sv, present only when SKID_EN=1.
- Handshakes: accept = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i. out_valid_o = mv.
- payload_o = mv ? M : (M & ~KILL_MASK). This is the only combinational output path besides in_ready_o when SKID_EN=0.
- Reset (rst_i=0 at the clock edge): mv=sv=0, M=S=RESET_VAL, in_ready_o=1, occupancy_o=0. Reset overrides flush and all handshakes. A reset mid-transfer discards both entries.
- Flush (rst_i=1, flush_i=1): mv=sv=0, M=S=RESET_VAL, in_ready_o=1 next cycle.
  - An input accepted in the flush cycle is dropped.
  - A pop in the flush cycle counts as delivered.
- SKID_EN=1 states, occ = mv+sv:
  - EMPTY (0): accept → M<=payload_i, go to ONE.
  - ONE (1):
    - accept&pop → M<=payload_i, stay ONE.
    - accept&~pop → S<=payload_i, go to FULL.
    - pop&~accept → EMPTY; M keeps its stale data (masked at the output).
    - neither → hold.
  - FULL (2): in_ready_o=0.
    - pop → M<=S, sv=0, go to ONE.
    - else hold.
  - in_ready_o is registered: next in_ready_o = ~next sv. No combinational path from out_ready_i to in_ready_o.
- SKID_EN=0: S, sv absent. in_ready_o = ~mv | out_ready_i (combinational).
  - accept → M<=payload_i, mv=1.
  - pop&~accept → mv=0.
  - Occupancy never exceeds 1.
- Latency: an accepted payload appears on payload_o with out_valid_o=1 in the next cycle when the stage was EMPTY, or when ONE and popping.
- Throughput: 1 transfer/cycle sustained when out_ready_i=1.
- Ordering: strict FIFO. S is never emitted before M.
- Invariant: sv=1 implies mv=1. Data is never overwritten while valid. in_valid_i without in_ready_o changes no state.
- occupancy_o = {sv&mv, mv^sv}, registered from state.

Test Plan:
- Reset: hold rst_i=0 two cycles with in_valid_i=1, payload_i=0xABCD → after release out_valid_o=0, payload_o=0, in_ready_o=1, occupancy_o=0.
- Streaming (SKID_EN=1): feed payloads 1..8, one per cycle, out_ready_i=1 → out_valid_o rises 1 cycle after the first accept; 1..8 emerge in consecutive cycles; occupancy_o stays at 1.
- Backpressure: out_ready_i=0 while sending 5,6,7 → 5 is in M and 6 is in S; in_ready_o=0 the cycle after 6 is accepted; 7 is held upstream. out_ready_i=1 then emits 5,6,7 in order with no loss or duplication.
- Bubble masking: KILL_MASK=0x000F, M last held 0x12345 and was popped → payload_o=0x12340 while out_valid_o=0.
- Flush in FULL with a simultaneous accept attempt → the next cycle shows occupancy_o=0, out_valid_o=0, payload_o=RESET_VAL-masked, in_ready_o=1; the next accepted value 0x55 appears alone.
- SKID_EN=0: out_ready_i toggling 1,0,1 with continuous input → in_ready_o follows ~mv|out_ready_i in the same cycle; order is preserved and occupancy_o never reaches 2.
